riio_sig_pad_ctrl: RTL and testbench
====================================

// Module: riio_sig_pad_ctrl
// PURPOSE
//  Digital pad controller that sits directly upstream of a signal IO cell and its bond pad.
//  It owns the drive side of one bidirectional pad: DO, OE and IE, including guard cycles on direction turnaround.
//  It returns a synchronised, glitch-filtered input level and edge pulses to the core.
//  Core logic never touches pad-side controls directly; it goes through this block.
// PARAMETERS
//  SYNC_STAGES  2  synchroniser flops on pad_di_i (>=2)
//  FILT_LEN     4  consecutive differing samples required to change rx_level_o (>=1)
//  TURN_CYCLES  2  guard cycles with OE=0 and IE=0 on every direction change (>=1)
//  CNT_W        4  counter width; must hold max(FILT_LEN, TURN_CYCLES)
// PORTS
//  clk          in   1  core clock
//  rst_n        in   1  reset, synchronous, active-low
//  mode_out_i   in   1  requested direction: 1 = drive pad, 0 = receive
//  tx_valid_i   in   1  tx bit valid
//  tx_data_i    in   1  bit to drive on pad
//  tx_ready_o   out  1  tx bit accepted this cycle when tx_valid_i=1
//  pad_do_o     out  1  to IO cell data-out
//  pad_oe_o     out  1  to IO cell output enable
//  pad_ie_o     out  1  to IO cell input enable
//  pad_di_i     in   1  from IO cell data-in (asynchronous)
//  rx_level_o   out  1  filtered input level
//  rx_rise_o    out  1  1-cycle pulse when rx_level_o changes 0->1
//  rx_fall_o    out  1  1-cycle pulse when rx_level_o changes 1->0
//  busy_o       out  1  1 while in TURN_OUT or TURN_IN
// BEHAVIOUR
//  - One clock, reset is synchronous and active-low.
//    While rst_n=0 at a clk edge, all flops clear: state=IN, pad_do/oe/ie=0, rx_level/rise/fall=0, sync chain=0, counters=0.
//  - pad_* controls and rx_* outputs are registered.
//    tx_ready_o = (state==OUT) & mode_out_i, combinational.
//  - FSM states: IN, TURN_OUT, OUT, TURN_IN.
//    IN:       oe=0, ie=1. If mode_out_i=1, go to TURN_OUT and load turn_cnt=TURN_CYCLES-1.
//    TURN_OUT: oe=0, ie=0. Decrement turn_cnt; at 0, go to OUT.
//    OUT:      oe=1, ie=0. If tx_valid_i & tx_ready_o, pad_do takes tx_data_i on the next edge; otherwise pad_do holds.
//              If mode_out_i=0, go to TURN_IN and load turn_cnt.
//    TURN_IN:  oe=0 from the first TURN_IN cycle, ie=0. At turn_cnt=0, go to IN.
//  - Outputs are registered from next state, so oe/ie change on the same edge as the state change.
//  - A full turnaround is exactly TURN_CYCLES cycles with oe=0 and ie=0. oe and ie are never both 1.
//  - mode_out_i is sampled only in IN and OUT. Toggles during TURN_* are ignored until the turnaround completes, then re-evaluated.
//  - pad_do_o is not cleared on leaving OUT; it holds its last value, which is harmless because oe=0.
//  - Input path: SYNC_STAGES flop chain feeds filt_cnt.
//    If sync_out != rx_level: filt_cnt increments. When filt_cnt==FILT_LEN-1, rx_level toggles on that edge, filt_cnt clears, and the matching edge pulse fires for 1 cycle.
//    If sync_out == rx_level: filt_cnt clears.
//    Latency from pad_di stable to rx_level: SYNC_STAGES+FILT_LEN edges (6 at defaults).
//  - Outside state IN: filt_cnt is held at 0 and rx_level_o holds. No edge pulses fire, because the IO cell input is disabled.
//    On re-entry to IN, the filter resumes from the current sync_out.
//  - A glitch shorter than FILT_LEN post-sync cycles never changes rx_level_o.
//  - Reset asserted mid-turnaround or mid-OUT: oe drops on the reset edge; after reset the block is in IN with ie=1 on the first edge.
// STRUCTURE
//  - Shared package riio_pad_pkg: pad_state_e {IN, TURN_OUT, OUT, TURN_IN}, reset constants for pad controls.
//  - Sub-module riio_pad_in_filter (SYNC_STAGES, FILT_LEN, CNT_W): sync chain, glitch counter, level and edge pulses, enable input.
//  - Top level holds the FSM, turn_cnt, tx register and pad control registers.
// TESTING
//  1. Reset, then idle with pad_di=1 for 8 cycles -> ie=1 one edge after reset release; rx_level=1 and rx_rise=1 pulse exactly 6 edges after the sync chain first sees 1.
//  2. mode_out=1 at cycle 10 -> oe=0, ie=0 for exactly 2 cycles (busy=1), then oe=1; tx_valid=1, data=1 -> pad_do=1 next edge, tx_ready=1 only in OUT.
//  3. In OUT drop mode_out -> oe=0 next edge, 2 guard cycles with ie=0, then ie=1; tx_valid during TURN_IN -> tx_ready=0, pad_do unchanged.
//  4. In IN, pad_di pulses low for 3 post-sync cycles -> no rx_fall, rx_level stays 1; low for 4 cycles -> rx_fall pulse, rx_level=0.
//  5. Toggle mode_out 1->0->1 inside TURN_OUT -> OUT still entered after 2 cycles, then TURN_IN starts because mode_out=0 is sampled in OUT.
//  6. rst_n=0 while oe=1 -> oe=0, pad_do=0, rx_level=0 on the reset edge; release -> state IN, ie=1 next edge.
//  Assert continuously: !(oe & ie), and every oe 0->1 is preceded by >=TURN_CYCLES cycles with ie=0.

Source files
------------

// File: rtl/riio_pad_pkg.sv
// Shared types and reset values for the signal pad controller.
package riio_pad_pkg;

  typedef enum logic [1:0] {
    IN       = 2'd0,
    TURN_OUT = 2'd1,
    OUT      = 2'd2,
    TURN_IN  = 2'd3
  } pad_state_e;

  localparam logic PAD_DO_RST = 1'b0;
  localparam logic PAD_OE_RST = 1'b0;
  localparam logic PAD_IE_RST = 1'b0;

  // {oe, ie} for a given state; only IN and OUT ever enable a buffer.
  function automatic logic [1:0] pad_ctrl_of(input pad_state_e s);
    logic [1:0] oe_ie;
    case (s)
      IN:       oe_ie = 2'b01;
      OUT:      oe_ie = 2'b10;
      TURN_OUT: oe_ie = 2'b00;
      TURN_IN:  oe_ie = 2'b00;
      default:  oe_ie = 2'b00;
    endcase
    return oe_ie;
  endfunction

endpackage

// File: rtl/riio_pad_in_filter.sv
// Pad input path: synchroniser chain, glitch filter, filtered level and edge pulses.
module riio_pad_in_filter
  import riio_pad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_pad_di,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;

  logic                   w_sync_out;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_level_nxt;
  logic                   w_rise_nxt;
  logic                   w_fall_nxt;

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  // Synchroniser keeps running while disabled so re-entry starts from a fresh sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{1'b0}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad_di};
    end
  end

  // Filter decision: a level change needs FILT_LEN consecutive differing samples.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    if (!i_en) begin
      w_cnt_nxt = {CNT_W{1'b0}};
    end else if (w_sync_out != r_level) begin
      if (r_cnt == FILT_LAST) begin
        w_cnt_nxt   = {CNT_W{1'b0}};
        w_level_nxt = ~r_level;
        w_rise_nxt  = ~r_level;
        w_fall_nxt  = r_level;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end else begin
      w_cnt_nxt = {CNT_W{1'b0}};
    end
  end

  // Filter state and registered level/pulse outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= {CNT_W{1'b0}};
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/riio_sig_pad_ctrl.sv
// Drive-side controller for one bidirectional pad: direction FSM with turnaround guard,
// tx data register, registered pad controls, and the filtered receive path.
module riio_sig_pad_ctrl
  import riio_pad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int TURN_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mode_out_i,
  input  logic tx_valid_i,
  input  logic tx_data_i,
  output logic tx_ready_o,
  output logic pad_do_o,
  output logic pad_oe_o,
  output logic pad_ie_o,
  input  logic pad_di_i,
  output logic rx_level_o,
  output logic rx_rise_o,
  output logic rx_fall_o,
  output logic busy_o
);

  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYCLES - 1);

  pad_state_e       r_state;
  logic [CNT_W-1:0] r_turn_cnt;
  logic             r_do;
  logic             r_oe;
  logic             r_ie;

  pad_state_e       w_state_nxt;
  logic [CNT_W-1:0] w_turn_cnt_nxt;
  logic             w_do_nxt;
  logic             w_oe_nxt;
  logic             w_ie_nxt;
  logic             w_tx_ready;
  logic             w_filt_en;

  assign w_tx_ready = (r_state == OUT) & mode_out_i;
  assign w_filt_en  = (r_state == IN);

  // Direction FSM; mode_out_i is only looked at in the two settled states.
  always_comb begin
    w_state_nxt    = r_state;
    w_turn_cnt_nxt = r_turn_cnt;
    w_do_nxt       = r_do;
    case (r_state)
      IN: begin
        if (mode_out_i) begin
          w_state_nxt    = TURN_OUT;
          w_turn_cnt_nxt = TURN_LAST;
        end else begin
          w_state_nxt = IN;
        end
      end
      TURN_OUT: begin
        if (r_turn_cnt == {CNT_W{1'b0}}) begin
          w_state_nxt = OUT;
        end else begin
          w_turn_cnt_nxt = r_turn_cnt - CNT_W'(1);
        end
      end
      OUT: begin
        if (tx_valid_i && w_tx_ready) begin
          w_do_nxt = tx_data_i;
        end else begin
          w_do_nxt = r_do;
        end
        if (!mode_out_i) begin
          w_state_nxt    = TURN_IN;
          w_turn_cnt_nxt = TURN_LAST;
        end else begin
          w_state_nxt = OUT;
        end
      end
      TURN_IN: begin
        if (r_turn_cnt == {CNT_W{1'b0}}) begin
          w_state_nxt = IN;
        end else begin
          w_turn_cnt_nxt = r_turn_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt    = IN;
        w_turn_cnt_nxt = {CNT_W{1'b0}};
      end
    endcase
    {w_oe_nxt, w_ie_nxt} = pad_ctrl_of(w_state_nxt);
  end

  // Pad controls are registered from the next state so they move with the state change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IN;
      r_turn_cnt <= {CNT_W{1'b0}};
      r_do       <= PAD_DO_RST;
      r_oe       <= PAD_OE_RST;
      r_ie       <= PAD_IE_RST;
    end else begin
      r_state    <= w_state_nxt;
      r_turn_cnt <= w_turn_cnt_nxt;
      r_do       <= w_do_nxt;
      r_oe       <= w_oe_nxt;
      r_ie       <= w_ie_nxt;
    end
  end

  riio_pad_in_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN),
    .CNT_W       (CNT_W)
  ) u_in_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (w_filt_en),
    .i_pad_di (pad_di_i),
    .o_level  (rx_level_o),
    .o_rise   (rx_rise_o),
    .o_fall   (rx_fall_o)
  );

  assign tx_ready_o = w_tx_ready;
  assign pad_do_o   = r_do;
  assign pad_oe_o   = r_oe;
  assign pad_ie_o   = r_ie;
  assign busy_o     = (r_state == TURN_OUT) || (r_state == TURN_IN);

endmodule

// File: tb/tb_riio_sig_pad_ctrl.sv
// Directed, table-driven bench for riio_sig_pad_ctrl at default parameters.
module tb_riio_sig_pad_ctrl;

  logic clk;
  logic rst_n;
  logic mode_out_i;
  logic tx_valid_i;
  logic tx_data_i;
  logic tx_ready_o;
  logic pad_do_o;
  logic pad_oe_o;
  logic pad_ie_o;
  logic pad_di_i;
  logic rx_level_o;
  logic rx_rise_o;
  logic rx_fall_o;
  logic busy_o;

  riio_sig_pad_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode_out_i (mode_out_i),
    .tx_valid_i (tx_valid_i),
    .tx_data_i  (tx_data_i),
    .tx_ready_o (tx_ready_o),
    .pad_do_o   (pad_do_o),
    .pad_oe_o   (pad_oe_o),
    .pad_ie_o   (pad_ie_o),
    .pad_di_i   (pad_di_i),
    .rx_level_o (rx_level_o),
    .rx_rise_o  (rx_rise_o),
    .rx_fall_o  (rx_fall_o),
    .busy_o     (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // inp = {rst_n, mode_out, tx_valid, tx_data, pad_di}
  // exp = {tx_ready (before edge), oe, ie, do, rx_level, rx_rise, rx_fall, busy (after edge)}
  typedef struct {
    logic [4:0] inp;
    logic [7:0] exp;
  } vec_t;

  localparam int NV = 52;
  vec_t vecs[NV];

  int n_chk;
  int n_fail;
  int guard_cnt;
  logic prev_oe;

  task automatic chk(input string name, input logic act, input logic req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Invariants sampled once per cycle: never oe&ie, and >=2 guard cycles before oe rises.
  task automatic inv_check();
    chk("oe_ie_exclusive", pad_oe_o & pad_ie_o, 1'b0);
    if (pad_oe_o && !prev_oe) begin
      n_chk++;
      if (guard_cnt < 2) begin
        n_fail++;
        $display("FAIL oe_guard: got %0d guard cycles, expected >= 2", guard_cnt);
      end
    end
    if (!pad_oe_o && !pad_ie_o) guard_cnt++;
    else guard_cnt = 0;
    prev_oe = pad_oe_o;
  endtask

  function automatic vec_t mk(input logic [4:0] inp, input logic [7:0] exp);
    vec_t v;
    v.inp = inp;
    v.exp = exp;
    return v;
  endfunction

  initial begin
    int   lat;
    logic found;

    n_chk = 0; n_fail = 0; guard_cnt = 0; prev_oe = 1'b0;
    rst_n = 1'b0; mode_out_i = 1'b0; tx_valid_i = 1'b0; tx_data_i = 1'b0; pad_di_i = 1'b1;

    // reset, then idle with pad_di=1: ie one edge after release, rise 6 edges after release
    vecs[0]  = mk(5'b00001, 8'b00000000);
    vecs[1]  = mk(5'b10001, 8'b00100000);
    vecs[2]  = mk(5'b10001, 8'b00100000);
    vecs[3]  = mk(5'b10001, 8'b00100000);
    vecs[4]  = mk(5'b10001, 8'b00100000);
    vecs[5]  = mk(5'b10001, 8'b00100000);
    vecs[6]  = mk(5'b10001, 8'b00101100);
    vecs[7]  = mk(5'b10001, 8'b00101000);
    vecs[8]  = mk(5'b10001, 8'b00101000);
    // turn out: 2 guard cycles, tx only accepted in OUT
    vecs[9]  = mk(5'b11001, 8'b00001001);
    vecs[10] = mk(5'b11111, 8'b00001001);
    vecs[11] = mk(5'b11111, 8'b01001000);
    vecs[12] = mk(5'b11111, 8'b11011000);
    vecs[13] = mk(5'b11101, 8'b11001000);
    vecs[14] = mk(5'b11011, 8'b11001000);
    vecs[15] = mk(5'b11111, 8'b11011000);
    // turn in: oe drops at once, tx ignored, ie after 2 guard cycles
    vecs[16] = mk(5'b10101, 8'b00011001);
    vecs[17] = mk(5'b10101, 8'b00011001);
    vecs[18] = mk(5'b10101, 8'b00111000);
    vecs[19] = mk(5'b10001, 8'b00111000);
    // 3-sample glitch low: filtered out
    vecs[20] = mk(5'b10000, 8'b00111000);
    vecs[21] = mk(5'b10000, 8'b00111000);
    vecs[22] = mk(5'b10000, 8'b00111000);
    vecs[23] = mk(5'b10001, 8'b00111000);
    vecs[24] = mk(5'b10001, 8'b00111000);
    vecs[25] = mk(5'b10001, 8'b00111000);
    vecs[26] = mk(5'b10001, 8'b00111000);
    // 4-sample low: fall pulse, then back high -> rise
    vecs[27] = mk(5'b10000, 8'b00111000);
    vecs[28] = mk(5'b10000, 8'b00111000);
    vecs[29] = mk(5'b10000, 8'b00111000);
    vecs[30] = mk(5'b10000, 8'b00111000);
    vecs[31] = mk(5'b10001, 8'b00111000);
    vecs[32] = mk(5'b10001, 8'b00110010);
    vecs[33] = mk(5'b10001, 8'b00110000);
    vecs[34] = mk(5'b10001, 8'b00110000);
    vecs[35] = mk(5'b10001, 8'b00110000);
    vecs[36] = mk(5'b10001, 8'b00111100);
    vecs[37] = mk(5'b10001, 8'b00111000);
    // mode toggles inside TURN_OUT/TURN_IN are ignored
    vecs[38] = mk(5'b11001, 8'b00011001);
    vecs[39] = mk(5'b10001, 8'b00011001);
    vecs[40] = mk(5'b11001, 8'b01011000);
    vecs[41] = mk(5'b10001, 8'b00011001);
    vecs[42] = mk(5'b11001, 8'b00011001);
    vecs[43] = mk(5'b11001, 8'b00111000);
    vecs[44] = mk(5'b11001, 8'b00011001);
    vecs[45] = mk(5'b11001, 8'b00011001);
    vecs[46] = mk(5'b11001, 8'b01011000);
    vecs[47] = mk(5'b11101, 8'b11001000);
    vecs[48] = mk(5'b11111, 8'b11011000);
    // reset while driving, then release
    vecs[49] = mk(5'b01111, 8'b10000000);
    vecs[50] = mk(5'b10001, 8'b00100000);
    vecs[51] = mk(5'b10001, 8'b00100000);

    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      inv_check();
      {rst_n, mode_out_i, tx_valid_i, tx_data_i, pad_di_i} = vecs[i].inp;
      #1;
      chk($sformatf("row%0d tx_ready", i), tx_ready_o, vecs[i].exp[7]);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d oe", i),    pad_oe_o,   vecs[i].exp[6]);
      chk($sformatf("row%0d ie", i),    pad_ie_o,   vecs[i].exp[5]);
      chk($sformatf("row%0d do", i),    pad_do_o,   vecs[i].exp[4]);
      chk($sformatf("row%0d level", i), rx_level_o, vecs[i].exp[3]);
      chk($sformatf("row%0d rise", i),  rx_rise_o,  vecs[i].exp[2]);
      chk($sformatf("row%0d fall", i),  rx_fall_o,  vecs[i].exp[1]);
      chk($sformatf("row%0d busy", i),  busy_o,     vecs[i].exp[0]);
    end

    // Wait (bounded) for the rise that follows the post-reset high input.
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      @(negedge clk);
      inv_check();
      @(posedge clk);
      #1;
      if (rx_rise_o) found = 1'b1;
    end
    chk("rise_after_reset", found, 1'b1);

    // Latency from pad_di falling to rx_fall pulse: 6 edges.
    @(negedge clk);
    inv_check();
    pad_di_i = 1'b0;
    lat = 0;
    found = 1'b0;
    for (int n = 1; n <= 12 && !found; n++) begin
      @(posedge clk);
      #1;
      if (rx_fall_o) begin
        found = 1'b1;
        lat = n;
      end
      @(negedge clk);
      inv_check();
    end
    chk_int("fall_latency", lat, 6);
    chk("fall_level", rx_level_o, 1'b0);
    @(posedge clk);
    #1;
    chk("fall_one_cycle", rx_fall_o, 1'b0);
    chk("fall_ie_held", pad_ie_o, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
